// File: rtl/add_arb_pkg.sv
// Shared constants, id-width helper and result record for the shared-adder arbiter.
package add_arb_pkg;

   localparam int W_DEF    = 8;
   localparam int NREQ_DEF = 4;

   // Smallest id width (at least one bit) able to encode n requesters.
   function automatic int id_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

   localparam int IDW_DEF = id_width(NREQ_DEF);

   typedef struct packed {
      logic [W_DEF-1:0]   sum;
      logic               carry;
      logic [IDW_DEF-1:0] id;
   } result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter
   import add_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o
);

   logic [NREQ-1:0] hi_s;
   logic [NREQ-1:0] sel_s;

   // Prefer requests at or above the pointer; otherwise fall back to the wrapped range.
   always_comb begin
      hi_s      = {NREQ{1'b0}};
      gnt_o     = {NREQ{1'b0}};
      gnt_idx_o = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         hi_s[i] = req_i[i] & (i >= int'(ptr_i));
      end
      sel_s = (|hi_s) ? hi_s : req_i;
      for (int i = NREQ - 1; i >= 0; i--) begin
         gnt_idx_o = sel_s[i] ? IDW'(i) : gnt_idx_o;
      end
      for (int i = 0; i < NREQ; i++) begin
         gnt_o[i] = en_i & (|req_i) & (gnt_idx_o == IDW'(i));
      end
   end

endmodule

// File: rtl/add_arbiter.sv
// One shared W-bit adder serving NREQ requesters in round-robin order,
// with a single registered valid/ready result channel.
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic              res_carry,
   output logic [IDW-1:0]    res_id
);

   logic            load_s;
   logic [NREQ-1:0] gnt_s;
   logic [IDW-1:0]  gnt_idx_s;
   logic            hs_s;
   logic [W-1:0]    op_a_s;
   logic [W-1:0]    op_b_s;
   logic [W:0]      sum_s;

   logic [IDW-1:0]  ptr_q, ptr_d;
   result_t         res_q, res_d;
   logic            res_valid_q, res_valid_d;

   assign load_s = ~res_valid_q | res_ready;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .en_i      (load_s & ~rst),
      .gnt_o     (gnt_s),
      .gnt_idx_o (gnt_idx_s)
   );

   assign req_ready = gnt_s;
   assign hs_s      = |(req_valid & gnt_s);

   // Steer the granted operand pair into the shared adder.
   always_comb begin
      op_a_s = {W{1'b0}};
      op_b_s = {W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         op_a_s = (gnt_idx_s == IDW'(i)) ? req_a[i*W +: W] : op_a_s;
         op_b_s = (gnt_idx_s == IDW'(i)) ? req_b[i*W +: W] : op_b_s;
      end
      sum_s = {1'b0, op_a_s} + {1'b0, op_b_s};
   end

   // Next state of the result register and round-robin pointer.
   always_comb begin
      res_d       = res_q;
      res_valid_d = res_valid_q;
      ptr_d       = ptr_q;
      if (hs_s) begin
         res_d.sum   = sum_s[W-1:0];
         res_d.carry = sum_s[W];
         res_d.id    = gnt_idx_s;
         res_valid_d = 1'b1;
         ptr_d       = (gnt_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1);
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end else begin
         res_valid_d = res_valid_q;
      end
   end

   // State registers; reset discards any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q       <= '0;
         res_valid_q <= 1'b0;
         ptr_q       <= {IDW{1'b0}};
      end else begin
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_sum   = res_q.sum;
   assign res_carry = res_q.carry;
   assign res_id    = res_q.id;

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one W-bit adder between NREQ independent requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle in round-robin order and registers the sum with carry and requester id.
- The result leaves on a single valid/ready output channel.
- Sits between the tile's input-decoding logic and the adder datapath.

Parameters:
- W, 8, operand and sum width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of res_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand pair valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing as req_a.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  W  (a+b) mod 2**W.
- res_carry  out  1  bit W of a+b.
- res_id  out  IDW  index of the requester that produced the result.

Behaviour:
- Reset (async, rst=1): res_valid=0, res_sum=0, res_carry=0, res_id=0, round-robin pointer=0. req_ready is all-zero while rst=1.
- Load condition: load = ~res_valid | res_ready. This allows full throughput of one result per cycle when downstream is always ready.
- Arbitration (combinational):
  - Search req_valid starting at pointer, wrapping modulo NREQ.
  - The first set index g is granted.
  - req_ready[i] = load & (i==g) & any(req_valid).
- Handshake on requester g (req_valid[g] & req_ready[g]):
  - Next edge: res_sum/res_carry <= a_g + b_g as a (W+1)-bit add; res_id <= g; res_valid <= 1.
  - Pointer <= (g+1) mod NREQ.
- No handshake, and res_valid & res_ready: res_valid <= 0. res_sum, res_carry and res_id keep their old values.
- No handshake, and result not consumed: all result outputs hold.
- Pointer advances only on a requester handshake, never on idle cycles.
- Latency: one cycle from requester handshake to res_valid.
- Backpressure: while res_valid=1 and res_ready=0, all req_ready=0 and result outputs are stable.
- Simultaneous consume + new grant in the same cycle: the result register reloads with no bubble.
- req_ready may depend combinationally on all req_valid bits and on res_ready.
- Requester protocol:
  - A requester must not make req_valid depend on req_ready.
  - Once asserted, req_valid and its operands hold until handshake (bench asserts this).
- Reset mid-operation: a pending result is discarded (res_valid drops asynchronously) and the pointer returns to 0. No handshake occurs while rst=1.

Decomposition:
- Package add_arb_pkg holds:
  - default W and NREQ constants;
  - a function clog2-style id width helper;
  - a result struct {sum, carry, id} used by the output register.
- Sub-module rr_arbiter (NREQ parameter):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant and encoded grant index;
  - purely combinational.
- The pointer register and the result register stay in add_arbiter.

Test Plan (W=8, NREQ=4):
- Reset: rst=1 with all req_valid=1 -> req_ready=0000, res_valid=0, res_sum=0x00, res_id=0. Release rst -> req_ready=0001 in the same cycle.
- Single request: req 0 a=0x12, b=0x34, res_ready=1 -> handshake; next cycle res_valid=1, res_sum=0x46, res_carry=0, res_id=0. The following cycle, with no request, res_valid=0.
- Overflow: req 2 a=0xF0, b=0x20 -> res_sum=0x10, res_carry=1, res_id=2. Separately, a=0xFF, b=0xFF -> res_sum=0xFE, res_carry=1.
- Round-robin fairness: all four req_valid held high, res_ready=1 -> res_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle, no bubbles.
- Backpressure: result id 1 valid, res_ready=0 for 3 cycles with req 2 and req 3 valid -> req_ready=0000 and res_sum/res_id stable. Raise res_ready -> req_ready=0100 that same cycle; next cycle res_id=2.
- Reset mid-op: res_valid=1 held by res_ready=0, pointer at 3 -> assert rst between edges; res_valid goes to 0 immediately. After release with all valids high, the first grant is requester 0.
